rtype_commit_checker: RTL and testbench
=======================================

RTYPE_COMMIT_CHECKER -- requirements
Module: rtype_commit_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 8: in-flight instruction FIFO entries, power of two, 2..32.
REQ-002 SHALL have parameter STOP_ON_ERR, default 1: 1 = enter FAIL on first error; 0 = keep checking.
REQ-003 SHALL have ports: clk input 1, the single clock.
REQ-004 SHALL have ports: reset input 1, asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have ports: init_we input 1, shadow register write strobe (INIT state only).
REQ-006 SHALL have ports: init_addr input 5, and init_data input 32, the shadow register index and value.
REQ-007 SHALL have ports: init_done input 1, one-cycle pulse ending INIT.
REQ-008 SHALL have ports: issue_valid input 1, and issue_instr input 32, an instruction accepted by the core front end.
REQ-009 SHALL have ports: wb_valid input 1, wb_waddr input 5, and wb_wdata input 32, the core register writeback.
REQ-010 SHALL have ports: state output 2 (0 INIT, 1 RUN, 2 FAIL), and fifo_count output $clog2(DEPTH)+1.
REQ-011 SHALL have ports: commit_count output 32, err_count output 16, and mismatch output 1 (sticky).
REQ-012 SHALL have ports: exp_addr output 5, and exp_data output 32, the last expected writeback (registered).

Function
REQ-013 SHALL hold a 32x32 shadow regfile; x0 reads 0 regardless of writes.
REQ-014 SHALL in INIT write shadow[init_addr]=init_data on init_we, and go to RUN the cycle after init_done; issue/wb ignored in INIT.
REQ-015 SHALL in RUN push issue_instr when issue_valid and opcode==7'b0110011 and funct7==0; all other instructions (e.g. 32'h00000013) are dropped silently.
REQ-016 SHALL on wb_valid pop the FIFO head, compute expected = ALU(funct3, shadow[rs1], shadow[rs2]), compare, then write shadow[rd]=expected; latency wb_valid->outputs is 1 cycle.
REQ-017 SHALL use ALU: 0 add, 1 sll by rs2[4:0], 2 slt signed, 3 sltu, 4 xor, 5 srl by rs2[4:0], 6 or, 7 and; 32-bit wrap on add.
REQ-018 SHALL flag an error when wb_waddr!=rd, or rd!=0 and wb_wdata!=expected; rd==0 compares address only.
REQ-019 SHALL flag an error on wb_valid with empty FIFO (spurious writeback); no pop, no shadow update.
REQ-020 SHALL flag an error on push when full and no simultaneous pop (overflow); the instruction is dropped.
REQ-021 SHALL allow a simultaneous push and pop when full; the count is unchanged and there is no error.
REQ-022 SHALL on any error set mismatch, and increment err_count saturating at 16'hFFFF; with STOP_ON_ERR=1 go to FAIL.
REQ-023 SHALL increment commit_count (wrapping) per checked pop, whether or not it mismatches.
REQ-024 SHALL in FAIL freeze the FIFO, shadow, and counters; leave FAIL only by reset.
REQ-025 SHALL read the shadow with RAW-correct ordering: a pop using rs of the immediately preceding pop's rd sees the updated value.

Reset
REQ-026 SHALL on reset low clear immediately: state=INIT, FIFO empty, fifo_count=0, commit_count=0, err_count=0, mismatch=0, exp_addr=0, exp_data=0.
REQ-027 SHALL leave shadow contents unspecified after reset (reloaded via INIT).
REQ-028 SHALL discard in-flight entries on reset mid-operation; no error is reported for them.

Structure
REQ-029 SHALL place the opcode/funct3 constants, the state encoding, and the ALU function in shared package sodor5_verif_pkg.
REQ-030 SHALL implement the FIFO as sub-module rtype_issue_fifo (DEPTH, 32-bit, count output).

Verification
REQ-031 SHALL cover: init x1=5, x2=7; issue add x3,x1,x2 (32'h002081B3); wb x3=12 -> commit_count=1, mismatch=0, exp_data=12.
REQ-032 SHALL cover: same as REQ-031 but wb_wdata=13 -> mismatch=1, err_count=1, state=FAIL next cycle.
REQ-033 SHALL cover: init x1=32'h80000000, x2=1; slt then sltu into x4 -> expected 1 then 0.
REQ-034 SHALL cover: 8 pushes with DEPTH=8, then push+pop together -> fifo_count stays 8, no error; a 9th lone push -> overflow error.
REQ-035 SHALL cover: wb_valid with empty FIFO -> err_count=1, shadow unchanged; with STOP_ON_ERR=0, state stays RUN.
REQ-036 SHALL cover: reset asserted with 3 entries in flight -> fifo_count=0, state=INIT within the same cycle, err_count=0.

Source files
------------

// File: rtl/sodor5_verif_pkg.sv
// Shared definitions for the R-type commit checker: instruction field layout,
// checker state encoding and the reference ALU used to predict writebacks.
package sodor5_verif_pkg;

   localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SRL  = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } chk_state_e;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rtype_fields_t;

   function automatic logic is_base_rtype(input logic [31:0] instr);
      return (instr[6:0] == OPC_RTYPE) && (instr[31:25] == FUNCT7_BASE);
   endfunction

   function automatic logic [31:0] alu(input logic [2:0]  funct3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      case (funct3)
         F3_ADD:  r = a + b;
         F3_SLL:  r = a << b[4:0];
         F3_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
         F3_SLTU: r = {31'd0, (a < b)};
         F3_XOR:  r = a ^ b;
         F3_SRL:  r = a >> b[4:0];
         F3_OR:   r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rtype_issue_fifo.sv
// In-flight instruction queue with a combinational head; the owner guarantees
// no push when full (unless popping) and no pop when empty.
module rtype_issue_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_i && !pop_i)      count_q <= count_q + (AW+1)'(1);
         else if (pop_i && !push_i) count_q <= count_q - (AW+1)'(1);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/rtype_commit_checker.sv
// Lockstep checker for RV32 base R-type commits: keeps a shadow regfile, queues
// issued instructions and compares every core writeback against the predicted result.
module rtype_commit_checker
   import sodor5_verif_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int STOP_ON_ERR = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     init_we,
   input  logic [4:0]               init_addr,
   input  logic [31:0]              init_data,
   input  logic                     init_done,
   input  logic                     issue_valid,
   input  logic [31:0]              issue_instr,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_waddr,
   input  logic [31:0]              wb_wdata,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              commit_count,
   output logic [15:0]              err_count,
   output logic                     mismatch,
   output logic [4:0]               exp_addr,
   output logic [31:0]              exp_data
);
   chk_state_e    state_q, state_d;
   logic [31:0]   shadow_q [32];
   logic [31:0]   commit_count_q;
   logic [15:0]   err_count_q;
   logic          mismatch_q;
   logic [4:0]    exp_addr_q;
   logic [31:0]   exp_data_q;

   logic          in_init, in_run;
   logic          fifo_full, fifo_empty;
   logic [31:0]   head_raw;
   rtype_fields_t head;
   logic          push_req, push, pop, spurious, overflow, data_err, any_err;
   logic [31:0]   rs1_val, rs2_val, expected;
   logic          unused_head_bits;

   assign in_init  = (state_q == ST_INIT);
   assign in_run   = (state_q == ST_RUN);
   assign push_req = in_run && issue_valid && is_base_rtype(issue_instr);
   assign pop      = in_run && wb_valid && !fifo_empty;
   assign spurious = in_run && wb_valid && fifo_empty;
   assign overflow = push_req && fifo_full && !pop;
   assign push     = push_req && !overflow;

   rtype_issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_ni  (reset),
      .push_i  (push),
      .wdata_i (issue_instr),
      .pop_i   (pop),
      .rdata_o (head_raw),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head             = head_raw;
   assign unused_head_bits = ^{head.funct7, head.opcode};

   // Combinational shadow read: a pop right after a write to the same rd sees the new value.
   assign rs1_val  = (head.rs1 == 5'd0) ? 32'd0 : shadow_q[head.rs1];
   assign rs2_val  = (head.rs2 == 5'd0) ? 32'd0 : shadow_q[head.rs2];
   assign expected = alu(head.funct3, rs1_val, rs2_val);

   assign data_err = pop && ((wb_waddr != head.rd) ||
                             ((head.rd != 5'd0) && (wb_wdata != expected)));
   assign any_err  = data_err || spurious || overflow;

   always_ff @(posedge clk) begin
      if (in_init && init_we) shadow_q[init_addr] <= init_data;
      else if (pop)           shadow_q[head.rd]   <= expected;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (init_done) state_d = ST_RUN;
         ST_RUN:  if (any_err && (STOP_ON_ERR != 0)) state_d = ST_FAIL;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         commit_count_q <= '0;
         err_count_q    <= '0;
         mismatch_q     <= 1'b0;
         exp_addr_q     <= '0;
         exp_data_q     <= '0;
      end else begin
         if (pop) begin
            commit_count_q <= commit_count_q + 32'd1;
            exp_addr_q     <= head.rd;
            exp_data_q     <= expected;
         end
         if (any_err) begin
            mismatch_q <= 1'b1;
            if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign state        = state_q;
   assign commit_count = commit_count_q;
   assign err_count    = err_count_q;
   assign mismatch     = mismatch_q;
   assign exp_addr     = exp_addr_q;
   assign exp_data     = exp_data_q;

endmodule

// File: tb/tb_rtype_commit_checker.sv
// Bench for rtype_commit_checker: two instances (stop-on-error and keep-going) share
// stimulus; a queue-based reference model plus ALU vector table and directed sequences.
module tb_rtype_commit_checker;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        init_we, init_done, issue_valid, wb_valid;
   logic [4:0]  init_addr, wb_waddr;
   logic [31:0] init_data, issue_instr, wb_wdata;

   logic [1:0]  o_state  [2];
   logic [3:0]  o_count  [2];
   logic [31:0] o_commit [2];
   logic [15:0] o_err    [2];
   logic        o_mis    [2];
   logic [4:0]  o_eaddr  [2];
   logic [31:0] o_edata  [2];

   int checks = 0;
   int failures = 0;

   // Reference model state, index 0 = stop-on-error instance, 1 = keep-going instance.
   int          m_state  [2];
   int          m_commit [2];
   int          m_err    [2];
   logic        m_mis    [2];
   logic [4:0]  m_eaddr  [2];
   logic [31:0] m_edata  [2];
   logic [31:0] m_sh     [2][32];
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;
   alu_vec_t vecs [9];

   always #5 clk = ~clk;

   rtype_commit_checker #(.DEPTH(DEPTH), .STOP_ON_ERR(1)) dut_a (
      .clk(clk), .reset(reset),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data), .init_done(init_done),
      .issue_valid(issue_valid), .issue_instr(issue_instr),
      .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .state(o_state[0]), .fifo_count(o_count[0]), .commit_count(o_commit[0]),
      .err_count(o_err[0]), .mismatch(o_mis[0]), .exp_addr(o_eaddr[0]), .exp_data(o_edata[0])
   );

   rtype_commit_checker #(.DEPTH(DEPTH), .STOP_ON_ERR(0)) dut_b (
      .clk(clk), .reset(reset),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data), .init_done(init_done),
      .issue_valid(issue_valid), .issue_instr(issue_instr),
      .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .state(o_state[1]), .fifo_count(o_count[1]), .commit_count(o_commit[1]),
      .err_count(o_err[1]), .mismatch(o_mis[1]), .exp_addr(o_eaddr[1]), .exp_data(o_edata[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input int f3, input int rd, input int rs1, input int rs2);
      logic [31:0] ins;
      ins = {7'd0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
      return ins;
   endfunction

   // Spec arithmetic: shifts as multiply/divide by a power of two, signed compare via int.
   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] pw;
      pw = 32'd1 << (b % 32);
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a * pw;
         3'd2:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return a / pw;
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] rd_sh(input int d, input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : m_sh[d][idx];
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q_a.size() : q_b.size();
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0; m_commit[d] = 0; m_err[d] = 0;
         m_mis[d] = 1'b0; m_eaddr[d] = '0; m_edata[d] = '0;
      end
      q_a.delete();
      q_b.delete();
   endtask

   task automatic model_step(input int d);
      logic [31:0] q[$];
      logic [31:0] ins, e;
      logic [4:0]  rd;
      logic        err;
      if (d == 0) q = q_a; else q = q_b;
      err = 1'b0;
      if (m_state[d] == 0) begin
         if (init_we) m_sh[d][init_addr] = init_data;
         if (init_done) m_state[d] = 1;
      end else if (m_state[d] == 1) begin
         if (wb_valid) begin
            if (q.size() == 0) err = 1'b1;
            else begin
               ins = q.pop_front();
               rd  = ins[11:7];
               e   = ref_alu(ins[14:12], rd_sh(d, ins[19:15]), rd_sh(d, ins[24:20]));
               m_commit[d]++;
               m_eaddr[d] = rd;
               m_edata[d] = e;
               if (wb_waddr != rd || (rd != 0 && wb_wdata != e)) err = 1'b1;
               m_sh[d][rd] = e;
            end
         end
         if (issue_valid && issue_instr[6:0] == 7'h33 && issue_instr[31:25] == 7'd0) begin
            if (q.size() >= DEPTH) err = 1'b1;
            else q.push_back(issue_instr);
         end
         if (err) begin
            m_mis[d] = 1'b1;
            if (m_err[d] < 65535) m_err[d]++;
            if (d == 0) m_state[d] = 2;
         end
      end
      if (d == 0) q_a = q; else q_b = q;
   endtask

   task automatic compare_all();
      string n;
      for (int d = 0; d < 2; d++) begin
         n = (d == 0) ? "A" : "B";
         chk({n, ".state"},        32'(o_state[d]),  32'(m_state[d]));
         chk({n, ".fifo_count"},   32'(o_count[d]),  32'(qsize(d)));
         chk({n, ".commit_count"}, o_commit[d],      32'(m_commit[d]));
         chk({n, ".err_count"},    32'(o_err[d]),    32'(m_err[d]));
         chk({n, ".mismatch"},     32'(o_mis[d]),    32'(m_mis[d]));
         chk({n, ".exp_addr"},     32'(o_eaddr[d]),  32'(m_eaddr[d]));
         chk({n, ".exp_data"},     o_edata[d],       m_edata[d]);
      end
   endtask

   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
      compare_all();
      init_we = 1'b0; init_done = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
   endtask

   // Called at a negedge: reset is dropped mid-cycle and checked before the next edge.
   task automatic do_reset();
      #2 reset = 1'b0;
      model_reset();
      #1 compare_all();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic init_load(input int addr, input logic [31:0] data);
      init_we = 1'b1; init_addr = 5'(addr); init_data = data;
      step();
   endtask

   task automatic init_finish();
      init_done = 1'b1;
      step();
   endtask

   task automatic issue(input logic [31:0] instr);
      issue_valid = 1'b1; issue_instr = instr;
      step();
   endtask

   task automatic wb(input int addr, input logic [31:0] data);
      wb_valid = 1'b1; wb_waddr = 5'(addr); wb_wdata = data;
      step();
      $display("wb x%0d=%h : A st=%0d commit=%0d err=%0d | B st=%0d commit=%0d err=%0d exp=%h",
               addr, data, o_state[0], o_commit[0], o_err[0], o_state[1], o_commit[1], o_err[1], o_edata[1]);
   endtask

   task automatic setup(input logic [31:0] x1, input logic [31:0] x2);
      do_reset();
      init_load(1, x1);
      init_load(2, x2);
      init_finish();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins, hd;
      logic        do_wb;
      int          r;

      vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,         32'd1};
      vecs[1] = '{3'd0, 32'd7,         32'd5,         32'd12};
      vecs[2] = '{3'd1, 32'd1,         32'h24,        32'h10};
      vecs[3] = '{3'd2, 32'hFFFF_FFFF, 32'd1,         32'd1};
      vecs[4] = '{3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0};
      vecs[5] = '{3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
      vecs[6] = '{3'd5, 32'h8000_0000, 32'h1F,        32'd1};
      vecs[7] = '{3'd6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
      vecs[8] = '{3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};

      reset = 1'b1;
      init_we = 1'b0; init_done = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
      init_addr = '0; init_data = '0; issue_instr = '0; wb_waddr = '0; wb_wdata = '0;
      model_reset();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++) m_sh[d][i] = '0;

      do_reset();
      chk("reset_state", 32'(o_state[0]), 32'd0);
      chk("reset_err",   32'(o_err[0]),   32'd0);

      // add x3,x1,x2 with correct writeback, then a RAW-dependent add x4,x3,x1
      setup(32'd5, 32'd7);
      issue(32'h002081B3);
      wb(3, 32'd12);
      chk("add_commit",   o_commit[0],      32'd1);
      chk("add_mismatch", 32'(o_mis[0]),    32'd0);
      chk("add_exp_data", o_edata[0],       32'd12);
      issue(rtype(0, 4, 3, 1));
      wb(4, 32'd17);
      chk("raw_exp_data", o_edata[0],       32'd17);
      chk("raw_err",      32'(o_err[0]),    32'd0);

      // wrong writeback data: stop instance enters FAIL
      setup(32'd5, 32'd7);
      issue(32'h002081B3);
      wb(3, 32'd13);
      chk("bad_mismatch", 32'(o_mis[0]),   32'd1);
      chk("bad_err",      32'(o_err[0]),   32'd1);
      chk("bad_state_a",  32'(o_state[0]), 32'd2);
      chk("bad_state_b",  32'(o_state[1]), 32'd1);

      // slt / sltu on 0x80000000 vs 1
      setup(32'h8000_0000, 32'd1);
      issue(32'h0020A233);
      wb(4, 32'd1);
      chk("slt_exp",  o_edata[0], 32'd1);
      issue(32'h0020B233);
      wb(4, 32'd0);
      chk("sltu_exp", o_edata[0], 32'd0);
      chk("slt_err",  32'(o_err[0]), 32'd0);

      // full FIFO: push+pop together is fine, a lone push overflows
      setup(32'd5, 32'd7);
      for (int i = 0; i < DEPTH; i++) issue(32'h002081B3);
      chk("full_count", 32'(o_count[0]), 32'd8);
      issue_valid = 1'b1; issue_instr = 32'h002081B3;
      wb(3, 32'd12);
      chk("pushpop_count", 32'(o_count[0]), 32'd8);
      chk("pushpop_err",   32'(o_err[0]),   32'd0);
      issue(32'h002081B3);
      chk("ovf_err_a",   32'(o_err[0]),   32'd1);
      chk("ovf_err_b",   32'(o_err[1]),   32'd1);
      chk("ovf_count_b", 32'(o_count[1]), 32'd8);
      chk("ovf_state_a", 32'(o_state[0]), 32'd2);

      // spurious writeback, dropped non-base instructions, shadow left intact
      setup(32'd5, 32'd7);
      wb(1, 32'd999);
      chk("spur_err_b",   32'(o_err[1]),   32'd1);
      chk("spur_state_b", 32'(o_state[1]), 32'd1);
      chk("spur_state_a", 32'(o_state[0]), 32'd2);
      issue(32'h0000_0013);
      issue(32'h4020_81B3);
      chk("drop_count_b", 32'(o_count[1]), 32'd0);
      issue(32'h002081B3);
      wb(3, 32'd12);
      chk("spur_shadow_b", o_edata[1],     32'd12);
      chk("spur_err2_b",   32'(o_err[1]),  32'd1);

      // reset with three entries in flight
      setup(32'd5, 32'd7);
      for (int i = 0; i < 3; i++) issue(32'h002081B3);
      chk("inflight_count", 32'(o_count[1]), 32'd3);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("rst_count", 32'(o_count[1]), 32'd0);
      chk("rst_state", 32'(o_state[1]), 32'd0);
      chk("rst_err",   32'(o_err[1]),   32'd0);
      @(negedge clk);
      reset = 1'b1;

      // ALU vector table
      for (int v = 0; v < 9; v++) begin
         setup(vecs[v].a, vecs[v].b);
         issue(rtype(int'(vecs[v].f3), 5, 1, 2));
         wb(5, vecs[v].exp);
         chk($sformatf("alu_vec%0d_data", v), o_edata[1],     vecs[v].exp);
         chk($sformatf("alu_vec%0d_mis", v),  32'(o_mis[1]),  32'd0);
      end

      // randomized traffic against the model
      do_reset();
      for (int i = 1; i < 32; i++)
         init_load(i, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      init_finish();
      for (int c = 0; c < 600; c++) begin
         issue_valid = ($urandom_range(0, 99) < 45);
         r = $urandom_range(0, 9);
         if (r == 0)      ins = 32'h0000_0013;
         else if (r == 1) ins = 32'h4000_0000 | rtype($urandom_range(0, 7), 3, 1, 2);
         else             ins = rtype($urandom_range(0, 7), $urandom_range(0, 7),
                                      $urandom_range(0, 7), $urandom_range(0, 7));
         issue_instr = ins;
         do_wb = ($urandom_range(0, 99) < 45);
         wb_valid = do_wb;
         if (q_b.size() > 0) begin
            hd = q_b[0];
            wb_waddr = hd[11:7];
            wb_wdata = ref_alu(hd[14:12], rd_sh(1, hd[19:15]), rd_sh(1, hd[24:20]));
            if ($urandom_range(0, 29) == 0) wb_wdata = wb_wdata ^ 32'h1;
            if ($urandom_range(0, 39) == 0) wb_waddr = wb_waddr + 5'd1;
         end else begin
            wb_waddr = 5'($urandom_range(0, 31));
            wb_wdata = $urandom;
         end
         step();
         if (do_wb)
            $display("rnd wb x%0d=%h : B commit=%0d err=%0d count=%0d",
                     wb_waddr, wb_wdata, o_commit[1], o_err[1], o_count[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
